// File: rtl/dir_enc_pkg.sv
// Shared types and constants for the directional tone-select encoder.
// Optional macro DIR_ENC_TIMEOUT_EN adds the LOCKOUT state.
package dir_enc_pkg;

`ifdef DIR_ENC_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1
    } state_t;
`endif

    localparam logic [2:0] SEL_OFF   = 3'b000;
    localparam logic [2:0] SEL_UP    = 3'b100;
    localparam logic [2:0] SEL_RIGHT = 3'b101;
    localparam logic [2:0] SEL_DOWN  = 3'b110;
    localparam logic [2:0] SEL_LEFT  = 3'b111;

    // dir code is the low two bits of the sel code; up > right > down > left
    function automatic logic [1:0] prio_dir(input logic [3:0] lvl);
        logic [1:0] d;
        if (lvl[3]) begin
            d = 2'b00;
        end else if (lvl[2]) begin
            d = 2'b01;
        end else if (lvl[1]) begin
            d = 2'b10;
        end else begin
            d = 2'b11;
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-disagreement debounce counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);
    import dir_enc_pkg::*;

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 32'd1);

    logic        sync1_r;
    logic        sync2_r;
    logic        level_r;
    logic [23:0] cnt_r;

    // synchronize, then toggle the level on the Nth consecutive differing cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= 24'd0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= ~level_r;
                    cnt_r   <= 24'd0;
                end else begin
                    cnt_r   <= cnt_r + 24'd1;
                end
            end else begin
                cnt_r <= 24'd0;
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/dir_sel_encoder.sv
// Debounced four-button direction encoder driving a tone-select code.
// Optional macro DIR_ENC_TIMEOUT_EN limits PLAY duration and adds LOCKOUT.
module dir_sel_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_ON_CYCLES   = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [2:0] sel,
    output logic       press_pulse
);
    import dir_enc_pkg::*;

    if (DEBOUNCE_CYCLES < 32'd1 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
        MAX_ON_CYCLES < 32'd1) begin : g_bad_param
        $error("dir_sel_encoder: parameter out of range");
    end

    logic [3:0] deb_s;
    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] dir_r;
    logic [1:0] next_dir_s;
    logic       pulse_r;
    logic       next_pulse_s;
    logic       held_s;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .level(deb_s[i])
        );
    end

`ifdef DIR_ENC_TIMEOUT_EN
    localparam logic [31:0] ON_LAST = 32'(MAX_ON_CYCLES - 32'd1);
    logic [31:0] on_cnt_r;

    // cycles spent in the current PLAY visit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_cnt_r <= 32'd0;
        end else if (state_r != ST_PLAY) begin
            on_cnt_r <= 32'd0;
        end else begin
            on_cnt_r <= on_cnt_r + 32'd1;
        end
    end
`endif

    // state, latched direction and entry strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            dir_r   <= 2'b00;
            pulse_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            dir_r   <= next_dir_s;
            pulse_r <= next_pulse_s;
        end
    end

    // next-state logic; dir code d maps to button bit 3-d
    always_comb begin
        next_state_s = state_r;
        next_dir_s   = dir_r;
        next_pulse_s = 1'b0;
        held_s       = deb_s[2'd3 - dir_r];
        case (state_r)
            ST_IDLE: begin
                if (|deb_s) begin
                    next_state_s = ST_PLAY;
                    next_dir_s   = prio_dir(deb_s);
                    next_pulse_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (!held_s) begin
                    next_state_s = ST_IDLE;
`ifdef DIR_ENC_TIMEOUT_EN
                end else if (on_cnt_r == ON_LAST) begin
                    next_state_s = ST_LOCKOUT;
`endif
                end else begin
                    next_state_s = ST_PLAY;
                end
            end
`ifdef DIR_ENC_TIMEOUT_EN
            ST_LOCKOUT: begin
                if (deb_s == 4'b0000) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_LOCKOUT;
                end
            end
`endif
            default: begin
                next_state_s = ST_IDLE;
                next_dir_s   = 2'b00;
            end
        endcase
    end

    // output decode from registered state only, so reset clears sel at once
    always_comb begin
        if (state_r == ST_PLAY) begin
            sel = {1'b1, dir_r};
        end else begin
            sel = SEL_OFF;
        end
    end

    assign press_pulse = pulse_r;

endmodule
